// File: rtl/multi_tick_pkg.sv
// multi_tick_pkg
//   Shared definitions for the multi-channel tick generator:
//   - MIN_DIV     : smallest divisor a channel accepts (a period of 1 has no
//                   room for both a low and a high square-wave phase).
//   - MAX_DIV_W   : widest counter/divisor the channel state record holds.
//   - ch_state_t  : per-channel state (counter, active divisor, shadow
//                   divisor, pending flag).
//   - default_div : reset divisor for a channel given the input clock rate.
package multi_tick_pkg;

  localparam int MIN_DIV   = 2;
  localparam int MAX_DIV_W = 32;

  // Fields are sized for the widest supported DIV_W; a channel masks every
  // value it stores to its own DIV_W, so the unused upper bits stay at zero.
  typedef struct packed {
    logic [MAX_DIV_W-1:0] cnt;   // position within the current period
    logic [MAX_DIV_W-1:0] div;   // active period in clocks
    logic [MAX_DIV_W-1:0] shd;   // shadow period, applied at the next wrap
    logic                 pend;  // shd holds a value not yet in div
  } ch_state_t;

  // ch0 = 1 Hz, ch1 = 2 Hz, ch2 = 1 kHz, ch3 = 100 Hz, others 1 Hz.
  // Slow input clocks can make a ratio collapse below MIN_DIV, so clamp.
  function automatic int default_div(input int ch, input int clk_hz);
    int d;
    case (ch)
      0:       d = clk_hz;
      1:       d = clk_hz / 2;
      2:       d = clk_hz / 1000;
      3:       d = clk_hz / 100;
      default: d = clk_hz;
    endcase
    if (d < MIN_DIV) d = MIN_DIV;
    return d;
  endfunction

endpackage

// File: rtl/multi_tick_gen_channel.sv
// tick_channel
//   One time base: counts clocks modulo its divisor, emits a one-cycle tick
//   at every wrap and a square wave at the same rate. A new divisor is
//   parked in a shadow register and swapped in at the next wrap, so no
//   shortened period is ever produced.
// Ports
//   clk_50MHz, reset_n : clock, asynchronous active-low reset
//   run                : channel may advance this cycle (global & per-channel enable)
//   clr                : synchronous clear; overrides run and wrap
//   wr, wr_div         : validated divisor write aimed at this channel
//   tick, sq           : registered tick pulse and square wave
//   pend               : a written divisor is waiting for the next wrap
// DIV_W must not exceed MAX_DIV_W; DEF_DIV must fit in DIV_W bits.
module tick_channel
  import multi_tick_pkg::*;
#(
  parameter int DIV_W   = 26,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  input  logic             run,
  input  logic             clr,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             tick,
  output logic             sq,
  output logic             pend
);

  // Keeps the counter increment inside DIV_W bits so the upper state bits
  // are provably constant.
  localparam logic [MAX_DIV_W-1:0] W_MASK  = MAX_DIV_W'((64'd1 << DIV_W) - 64'd1);
  localparam logic [MAX_DIV_W-1:0] RST_DIV = MAX_DIV_W'(DEF_DIV) & W_MASK;

  ch_state_t            st_reg, st_next;
  logic                 tick_reg, tick_next;
  logic                 sq_reg, sq_next;

  logic [MAX_DIV_W-1:0] wr_ext;
  logic [MAX_DIV_W-1:0] cnt_inc;
  logic [MAX_DIV_W-1:0] cnt_adv;
  logic                 last;

  assign wr_ext  = MAX_DIV_W'(wr_div);
  assign last    = (st_reg.cnt == (st_reg.div - MAX_DIV_W'(1)));
  assign cnt_inc = (st_reg.cnt + MAX_DIV_W'(1)) & W_MASK;
  assign cnt_adv = last ? '0 : cnt_inc;

  always_comb begin
    st_next   = st_reg;
    tick_next = 1'b0;
    sq_next   = sq_reg;

    if (clr) begin
      // A write arriving with the clear is taken as the new period at once;
      // otherwise any shadow value is applied (shd equals div when idle).
      st_next.div  = wr ? wr_ext : st_reg.shd;
      st_next.shd  = wr ? wr_ext : st_reg.shd;
      st_next.cnt  = '0;
      st_next.pend = 1'b0;
      sq_next      = 1'b0;
    end else begin
      if (run) begin
        st_next.cnt = cnt_adv;
        tick_next   = last;
        // Low for the first floor(div/2) counts of the period, high after.
        // On a wrap cnt_adv is 0, which is below any legal half period.
        sq_next     = (cnt_adv >= (st_reg.div >> 1));
        if (last && st_reg.pend) begin
          st_next.div  = st_reg.shd;
          st_next.pend = 1'b0;
        end
      end
      // Evaluated after the wrap so a write landing on the wrap edge stays
      // pending for the following period.
      if (wr) begin
        st_next.shd  = wr_ext;
        st_next.pend = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      st_reg   <= '{cnt: '0, div: RST_DIV, shd: RST_DIV, pend: 1'b0};
      tick_reg <= 1'b0;
      sq_reg   <= 1'b0;
    end else begin
      st_reg   <= st_next;
      tick_reg <= tick_next;
      sq_reg   <= sq_next;
    end
  end

  assign tick = tick_reg;
  assign sq   = sq_reg;
  assign pend = st_reg.pend;

endmodule

// File: rtl/multi_tick_gen.sv
// multi_tick_gen
//   NUM_CH independent tick/square-wave time bases derived from clk_50MHz,
//   each with a runtime-programmable divisor applied at its next wrap.
// Ports
//   clk_50MHz, reset_n : clock, asynchronous active-low reset
//   en, ch_en          : global and per-channel run enables
//   sync_clr           : synchronous clear of all channels
//   cfg_wr/ch/div      : one-cycle divisor write (period in clocks)
//   cfg_err            : one-cycle pulse after a rejected write
//   cfg_pend           : per-channel "divisor written but not yet applied"
//   tick, sq           : per-channel tick pulse and square wave
// Parameters: CLK_HZ sets reset divisors; NUM_CH in 1..16;
//   DIV_W must satisfy 2**DIV_W > CLK_HZ and DIV_W <= 32.
module multi_tick_gen
  import multi_tick_pkg::*;
#(
  parameter int  CLK_HZ = 50_000_000,
  parameter int  NUM_CH = 4,
  parameter int  DIV_W  = 26,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] cfg_pend,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  logic cfg_ch_ok;
  logic cfg_div_ok;
  logic cfg_valid;
  logic cfg_err_reg;

  // cfg_ch can address past the last channel when NUM_CH is not a power of 2.
  assign cfg_ch_ok  = (int'(cfg_ch) < NUM_CH);
  assign cfg_div_ok = (cfg_div >= DIV_W'(MIN_DIV));
  assign cfg_valid  = cfg_wr & cfg_ch_ok & cfg_div_ok;

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= cfg_wr & ~cfg_valid;
    end
  end

  assign cfg_err = cfg_err_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      tick_channel #(
        .DIV_W   (DIV_W),
        .DEF_DIV (default_div(gi, CLK_HZ))
      ) u_ch (
        .clk_50MHz (clk_50MHz),
        .reset_n   (reset_n),
        .run       (en & ch_en[gi]),
        .clr       (sync_clr),
        .wr        (cfg_valid && (cfg_ch == CH_W'(gi))),
        .wr_div    (cfg_div),
        .tick      (tick[gi]),
        .sq        (sq[gi]),
        .pend      (cfg_pend[gi])
      );
    end
  endgenerate

endmodule
